// File: rtl/activation_writer_bram.sv
// Streams a snapshot of a flat element vector into a single-port BRAM, one
// element per cycle, then optionally reads every word back and counts mismatches.
module activation_writer_bram #(
   parameter int NUM_ELEMS  = 8,
   parameter int W          = 8,
   parameter int ADDR_WIDTH = 15,
   parameter int BASE_ADDR  = 0,
   parameter int VERIFY_EN  = 1,
   parameter int CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NUM_ELEMS*W-1:0] data_in,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [CNT_W-1:0]       mismatch_count,
   output logic                   bram_en,
   output logic                   bram_ren,
   output logic                   bram_wen,
   output logic [ADDR_WIDTH-1:0]  bram_addr,
   output logic [W-1:0]           bram_din,
   input  logic [W-1:0]           bram_dout
);

   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

   localparam int unsigned          N    = NUM_ELEMS;
   localparam int                   IW   = $clog2(NUM_ELEMS + 2) + 1;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   state_t                 state, state_nx;
   logic [IW-1:0]          cnt, cnt_nx;
   logic [NUM_ELEMS*W-1:0] snap, snap_nx;
   logic [CNT_W-1:0]       mm_nx;
   logic                   busy_nx, done_nx, error_nx;
   logic                   en_nx, ren_nx, wen_nx;
   logic [ADDR_WIDTH-1:0]  addr_nx;
   logic [W-1:0]           din_nx;
   int unsigned            k;

   // Next-state and next-output computation; every output is registered below.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      snap_nx  = snap;
      mm_nx    = mismatch_count;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      error_nx = 1'b0;
      en_nx    = 1'b0;
      ren_nx   = 1'b0;
      wen_nx   = 1'b0;
      addr_nx  = '0;
      din_nx   = '0;
      k        = 32'(cnt);

      case (state)
         IDLE, DONE: begin
            done_nx  = (state == DONE);
            error_nx = (state == DONE) && error;
            if (start) begin
               snap_nx  = data_in;
               mm_nx    = '0;
               cnt_nx   = '0;
               state_nx = WRITE;
               busy_nx  = 1'b1;
               done_nx  = 1'b0;
               error_nx = 1'b0;
               en_nx    = 1'b1;
               wen_nx   = 1'b1;
               addr_nx  = BASE;
               din_nx   = data_in[W-1:0];
            end
         end

         WRITE: begin
            busy_nx = 1'b1;
            if (k + 1 < N) begin
               cnt_nx  = IW'(k + 1);
               en_nx   = 1'b1;
               wen_nx  = 1'b1;
               addr_nx = BASE + ADDR_WIDTH'(k + 1);
               din_nx  = snap[(k + 1) * W +: W];
            end else if (k + 1 == N && VERIFY_EN != 0) begin
               state_nx = VERIFY;
               cnt_nx   = '0;
               en_nx    = 1'b1;
               ren_nx   = 1'b1;
               addr_nx  = BASE;
            end else if (k + 1 == N) begin
               // without read-back, one idle tail cycle separates the last write from DONE
               cnt_nx = IW'(N);
            end else begin
               state_nx = DONE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               error_nx = (mismatch_count != '0);
            end
         end

         VERIFY: begin
            busy_nx = 1'b1;
            // read data for address k-2 arrives this cycle
            if (k >= 2) begin
               if (bram_dout != snap[(k - 2) * W +: W] && mismatch_count != '1)
                  mm_nx = mismatch_count + 1'b1;
            end
            if (k == N + 1) begin
               state_nx = DONE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               error_nx = (mm_nx != '0);
            end else begin
               cnt_nx = IW'(k + 1);
               en_nx  = 1'b1;
               if (k + 1 < N) begin
                  ren_nx  = 1'b1;
                  addr_nx = BASE + ADDR_WIDTH'(k + 1);
               end
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // State, counters, snapshot and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         snap           <= '0;
         mismatch_count <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         bram_en        <= 1'b0;
         bram_ren       <= 1'b0;
         bram_wen       <= 1'b0;
         bram_addr      <= '0;
         bram_din       <= '0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         snap           <= snap_nx;
         mismatch_count <= mm_nx;
         busy           <= busy_nx;
         done           <= done_nx;
         error          <= error_nx;
         bram_en        <= en_nx;
         bram_ren       <= ren_nx;
         bram_wen       <= wen_nx;
         bram_addr      <= addr_nx;
         bram_din       <= din_nx;
      end
   end

endmodule

// File: doc/activation_writer_bram.md
Name: activation_writer_bram

Overview:
- Opposite end of the BRAM weight-loading path. The BRAM weight loaders unpack BRAM contents into a flat vector; this block takes a flat vector and writes it into BRAM, one element per cycle.
- Typical use: storing a layer's output activations. An optional read-back pass verifies every written word.
- Drives the same single-port BRAM interface: en, ren, wen, addr, din, dout, with 2-cycle read latency.

Parameters:
- NUM_ELEMS, 8: number of W-bit elements in data_in.
- W, 8: element width in bits.
- ADDR_WIDTH, 15: BRAM address width.
- BASE_ADDR, 0: BRAM address of element 0.
- VERIFY_EN, 1: 1 enables the read-back pass; 0 skips it.
- CNT_W, 16: width of mismatch_count.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a transfer; sampled in IDLE and DONE only.
- data_in  input  NUM_ELEMS*W  flat vector; element i is data_in[i*W +: W].
- busy  output  1  high in WRITE and VERIFY.
- done  output  1  high in DONE.
- error  output  1  high in DONE if mismatch_count != 0.
- mismatch_count  output  CNT_W  number of read-back mismatches, saturating at all-ones.
- bram_en  output  1  BRAM enable.
- bram_ren  output  1  BRAM read enable.
- bram_wen  output  1  BRAM write enable.
- bram_addr  output  ADDR_WIDTH  BRAM address.
- bram_din  output  W  BRAM write data.
- bram_dout  input  W  BRAM read data; valid 2 cycles after the read address.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset (asserted at any time, including mid-transfer):
  - state goes to IDLE.
  - All outputs go to 0, and internal counters and the snapshot clear.
  - BRAM words already written stay written; no rollback.
- Registered outputs only; no combinational path from inputs to outputs.
- IDLE:
  - Outputs idle (all BRAM controls 0).
  - On start=1 at edge T: snapshot data_in into an internal register.
  - After T: state=WRITE, bram_en=1, bram_wen=1, bram_addr=BASE_ADDR, bram_din=element 0.
- WRITE:
  - Each edge advances one element. Cycle k presents addr BASE_ADDR+k and din element k.
  - Exactly NUM_ELEMS write cycles, element 0 first.
  - After the last write: bram_wen=0. Go to VERIFY if VERIFY_EN=1, else to DONE with bram_en=0.
  - Write phase latency: done rises NUM_ELEMS+1 edges after the start edge when VERIFY_EN=0.
- VERIFY:
  - Issue reads: bram_en=1, bram_ren=1, addr BASE_ADDR+k for k=0..NUM_ELEMS-1, one per cycle.
  - Compare the bram_dout sampled 2 cycles after each address against snapshot element k.
  - Each mismatch increments mismatch_count, saturating.
  - bram_ren drops after the last address; bram_en stays high until the final compare.
  - Leave VERIFY after NUM_ELEMS compares; total VERIFY duration is NUM_ELEMS+2 cycles.
- DONE:
  - done=1, busy=0, BRAM controls 0.
  - error and mismatch_count hold.
  - start=1 in DONE clears mismatch_count and error, re-snapshots data_in and enters WRITE exactly as from IDLE.
- start in WRITE or VERIFY is ignored.
- data_in changes after the start edge are ignored.
- Address arithmetic: BASE_ADDR+k is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- bram_ren and bram_wen are never high in the same cycle.
- NUM_ELEMS=1 is legal: 1 write cycle; VERIFY lasts 3 cycles.

Test Plan:
- NUM_ELEMS=4, W=8, BASE_ADDR=16, VERIFY_EN=0, data_in=32'h44332211, 1-cycle start pulse:
  - Addr 16,17,18,19 written with 11,22,33,44 on 4 consecutive cycles.
  - done=1 at the 5th edge after start; busy=0.
- Same setup with VERIFY_EN=1:
  - Reads of 16..19 follow the writes.
  - done after 4+6 cycles; mismatch_count=0, error=0.
- VERIFY_EN=1, BRAM model corrupts addr 18 to 8'hFF after the write:
  - mismatch_count=1, error=1 in DONE.
- Assert rst_n=0 after 2 write cycles:
  - All outputs 0 immediately (asynchronous), state IDLE.
  - BRAM holds only addr 16=11 and 17=22.
  - Further start works normally.
- Change data_in to 32'hDEADBEEF one cycle after start; pulse start again during WRITE:
  - Original 11,22,33,44 are written.
  - The second start is ignored; no extra cycles.
- From DONE with error=1, pulse start with data_in=32'h0A0B0C0D:
  - error and mismatch_count clear.
  - Addr 16..19 receive 0D,0C,0B,0A.
